adc_frame_packer: RTL

- Stage directly downstream of the LVDS front-end, in the sys_clk domain.
- Consumes the front-end's output word stream (valid/ready) and groups FRAME_LEN sample words into a frame.
- Each frame is a SYNC header, a sequence-number header, FRAME_LEN payload words and an XOR checksum trailer.
- Emits frames as a valid/ready/last stream to the DMA/transport stage.

---
 rtl/adc_frame_pkg.sv | 20 ++
 rtl/adc_frame_packer_stream_out_reg.sv | 41 ++++
 rtl/adc_frame_packer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/adc_frame_pkg.sv
// Shared types and helpers for the ADC frame packer and neighbouring sys_clk stages.
package adc_frame_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HDR_SYNC = 3'd1,
      HDR_SEQ  = 3'd2,
      PAYLOAD  = 3'd3,
      TRAILER  = 3'd4
   } frame_state_e;

   localparam int SEQ_W     = 16;
   localparam int HDR_MAX_W = 64;

   // Callers narrow the result to their own word width with a size cast.
   function automatic logic [HDR_MAX_W-1:0] hdr_word_ext(input logic [SEQ_W-1:0] w);
      return HDR_MAX_W'(w);
   endfunction

endpackage

// File: rtl/adc_frame_packer_stream_out_reg.sv
// Registered valid/ready output stage: one cycle load-to-output latency.
// Loads when empty or drained (o_adv); holds data/valid/last stable while stalled.
module stream_out_reg #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ld_vld,
   input  logic [WIDTH-1:0] i_ld_dat,
   input  logic             i_ld_last,
   input  logic             i_rdy,
   output logic             o_vld,
   output logic [WIDTH-1:0] o_dat,
   output logic             o_last,
   output logic             o_adv
);

   logic             r_vld;
   logic [WIDTH-1:0] r_dat;
   logic             r_last;

   assign o_adv  = !r_vld || i_rdy;
   assign o_vld  = r_vld;
   assign o_dat  = r_dat;
   assign o_last = r_last;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vld  <= 1'b0;
         r_dat  <= '0;
         r_last <= 1'b0;
      end else if (o_adv) begin
         r_vld  <= i_ld_vld;
         r_last <= i_ld_vld && i_ld_last;
         if (i_ld_vld) begin
            r_dat <= i_ld_dat;
         end
      end
   end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs FRAME_LEN sample words into SYNC/SEQ/payload/XOR-trailer frames; one register stage to out_*.
// Payload input is only accepted while the output stage can advance; stalls propagate straight to in_ready.
module adc_frame_packer
   import adc_frame_pkg::*;
#(
   parameter int          WIDTH     = 16,
   parameter int          FRAME_LEN = 256,
   parameter logic [15:0] SYNC_WORD = 16'hA5A5
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] in_word,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic [15:0]      frame_count,
   output logic             busy
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   frame_state_e     r_state;
   frame_state_e     w_state_nxt;
   logic [SEQ_W-1:0] r_seq;
   logic [WIDTH-1:0] r_csum;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_frame_cnt;

   logic             w_adv;
   logic             w_accept;
   logic             w_last_word;
   logic             w_ld_vld;
   logic             w_ld_last;
   logic [WIDTH-1:0] w_ld_dat;
   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_seq_word;

   assign w_sync      = WIDTH'(hdr_word_ext(SYNC_WORD));
   assign w_seq_word  = WIDTH'(hdr_word_ext(r_seq));
   // Gating with reset keeps a word from being consumed into a frame that is being dropped.
   assign in_ready    = (r_state == PAYLOAD) && w_adv && !sys_rst;
   assign w_accept    = in_valid && in_ready;
   assign w_last_word = (r_cnt == CNT_W'(FRAME_LEN - 1));
   assign busy        = (r_state != IDLE);
   assign frame_count = r_frame_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_ld_vld    = 1'b0;
      w_ld_last   = 1'b0;
      w_ld_dat    = '0;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_state_nxt = HDR_SYNC;
            end
         end
         HDR_SYNC: begin
            if (w_adv) begin
               w_ld_vld    = 1'b1;
               w_ld_dat    = w_sync;
               w_state_nxt = HDR_SEQ;
            end
         end
         HDR_SEQ: begin
            if (w_adv) begin
               w_ld_vld    = 1'b1;
               w_ld_dat    = w_seq_word;
               w_state_nxt = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (w_accept) begin
               w_ld_vld = 1'b1;
               w_ld_dat = in_word;
               if (w_last_word) begin
                  w_state_nxt = TRAILER;
               end
            end
         end
         TRAILER: begin
            if (w_adv) begin
               w_ld_vld    = 1'b1;
               w_ld_last   = 1'b1;
               w_ld_dat    = r_csum;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state     <= IDLE;
         r_seq       <= '0;
         r_csum      <= '0;
         r_cnt       <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_csum <= r_csum ^ in_word;
            r_cnt  <= w_last_word ? '0 : r_cnt + CNT_W'(1);
         end
         if ((r_state == TRAILER) && w_adv) begin
            r_csum <= '0;
            r_seq  <= r_seq + SEQ_W'(1);
         end
         // Counted on trailer acceptance, which may land after the next frame has started.
         if (out_valid && out_ready && out_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   stream_out_reg #(
      .WIDTH(WIDTH)
   ) u_out_reg (
      .i_clk    (sys_clk),
      .i_rst    (sys_rst),
      .i_ld_vld (w_ld_vld),
      .i_ld_dat (w_ld_dat),
      .i_ld_last(w_ld_last),
      .i_rdy    (out_ready),
      .o_vld    (out_valid),
      .o_dat    (out_data),
      .o_last   (out_last),
      .o_adv    (w_adv)
   );

endmodule
